// File: rtl/qpsk_phase_sync_ctrl.sv
// Receive-side phase sweep controller: paces the PRBS with a symbol strobe, measures the
// bit errors at each of the four rx sampling phases, then locks onto the best phase.
module qpsk_phase_sync_ctrl #(
    parameter int unsigned OS      = 4,
    parameter int unsigned LAT     = 16,
    parameter int unsigned SETTLE  = 32,
    parameter int unsigned WINDOW  = 1024,
    parameter int unsigned ERR_W   = 11,
    parameter int unsigned ERR_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             ref_bit_i,
    input  logic             rx_bit_i,
    output logic             sym_en_o,
    output logic             enable_dp_o,
    output logic [1:0]       phase_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             locked_o,
    output logic [1:0]       best_phase_o,
    output logic [ERR_W-1:0] best_err_o
);

    localparam int unsigned DIV_W   = (OS > 1) ? $clog2(OS) : 1;
    localparam int unsigned CNT_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ERR_W-1:0] ERR_SAT = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_EVAL    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic               sym_en_q;
    logic               en_dp_q;
    logic [LAT-1:0]     dline_q, dline_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [1:0]         phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               locked_q, locked_d;
    logic [1:0]         best_phase_q, best_phase_d;
    logic [ERR_W-1:0]   best_err_q, best_err_d;
    logic               div_wrap_c;
    logic               err_evt_c;
    logic               take_best_c;

    assign div_wrap_c  = (div_q == DIV_W'(OS - 1));
    assign err_evt_c   = sym_en_q && (state_q == S_MEASURE) && (rx_bit_i != dline_q[LAT-1]);
    assign take_best_c = (phase_q == 2'd0) || (err_q < best_err_q);

    // Reference delay line: newest bit enters at index 0, oldest is compared.
    always_comb begin
        dline_d    = dline_q << 1;
        dline_d[0] = ref_bit_i;
    end

    // Free-running symbol divider, strobe and reference delay line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            sym_en_q <= 1'b0;
            en_dp_q  <= 1'b0;
            dline_q  <= '0;
        end else begin
            div_q    <= div_wrap_c ? '0 : div_q + 1'b1;
            sym_en_q <= div_wrap_c;
            en_dp_q  <= 1'b1;
            if (sym_en_q) begin
                dline_q <= dline_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (sym_en_q && cnt_q == CNT_W'(SETTLE - 1)) state_d = S_MEASURE;
            end
            S_MEASURE: begin
                if (sym_en_q && cnt_q == CNT_W'(WINDOW - 1)) state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = (phase_q == 2'd3) ? S_DONE : S_SETTLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        err_d        = err_q;
        phase_d      = phase_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        locked_d     = locked_q;
        best_phase_d = best_phase_q;
        best_err_d   = best_err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    phase_d  = 2'd0;
                    busy_d   = 1'b1;
                    locked_d = 1'b0;
                    cnt_d    = '0;
                    err_d    = '0;
                end
            end
            S_SETTLE: begin
                if (sym_en_q) begin
                    cnt_d = (cnt_q == CNT_W'(SETTLE - 1)) ? '0 : cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (sym_en_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (err_evt_c && err_q != ERR_SAT) begin
                    err_d = err_q + 1'b1;
                end
            end
            S_EVAL: begin
                // Strict compare: on a tie the earlier (lower) phase is kept.
                if (take_best_c) begin
                    best_err_d   = err_q;
                    best_phase_d = phase_q;
                end
                if (phase_q == 2'd3) begin
                    phase_d  = best_phase_d;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    locked_d = (32'(best_err_d) <= ERR_MAX);
                end else begin
                    phase_d = phase_q + 2'd1;
                    cnt_d   = '0;
                    err_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            err_q        <= '0;
            phase_q      <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            best_phase_q <= 2'd0;
            best_err_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            locked_q     <= locked_d;
            best_phase_q <= best_phase_d;
            best_err_q   <= best_err_d;
        end
    end

    assign sym_en_o     = sym_en_q;
    assign enable_dp_o  = en_dp_q;
    assign phase_out_o  = phase_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign locked_o     = locked_q;
    assign best_phase_o = best_phase_q;
    assign best_err_o   = best_err_q;

endmodule

// File: tb/tb_qpsk_phase_sync_ctrl.sv
// Randomized bench for qpsk_phase_sync_ctrl: drives a random PRBS and a delayed rx stream with
// planned error injections, and predicts each sweep's outcome from per-phase error counts.
module tb_qpsk_phase_sync_ctrl;

    localparam int unsigned OS_T  = 4;
    localparam int unsigned LAT_T = 16;
    localparam int unsigned S_T   = 32;
    localparam int unsigned W_T   = 1024;
    localparam int unsigned EW_T  = 11;
    localparam int unsigned EM_T  = 8;
    localparam int unsigned PH_SYM = S_T + W_T;
    localparam int unsigned LEN_LO = (4 * PH_SYM - 1) * OS_T + 2;
    localparam int unsigned LEN_HI = LEN_LO + OS_T - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i, ref_bit_i, rx_bit_i;
    logic            sym_en_o, enable_dp_o, busy_o, done_o, locked_o;
    logic [1:0]      phase_out_o, best_phase_o;
    logic [EW_T-1:0] best_err_o;

    logic            start2, ref2, rx2;
    logic            s_sym, s_en, s_busy, s_done, s_locked;
    logic [1:0]      s_phase, s_bphase;
    logic [3:0]      s_berr;

    always #5 clk = ~clk;

    qpsk_phase_sync_ctrl #(
        .OS(OS_T), .LAT(LAT_T), .SETTLE(S_T), .WINDOW(W_T), .ERR_W(EW_T), .ERR_MAX(EM_T)
    ) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .ref_bit_i(ref_bit_i), .rx_bit_i(rx_bit_i),
        .sym_en_o(sym_en_o), .enable_dp_o(enable_dp_o), .phase_out_o(phase_out_o),
        .busy_o(busy_o), .done_o(done_o), .locked_o(locked_o),
        .best_phase_o(best_phase_o), .best_err_o(best_err_o)
    );

    // Narrow error counter instance used to exercise saturation.
    qpsk_phase_sync_ctrl #(
        .OS(2), .LAT(3), .SETTLE(4), .WINDOW(32), .ERR_W(4), .ERR_MAX(2)
    ) u_sat (
        .clk(clk), .rst(rst), .start_i(start2), .ref_bit_i(ref2), .rx_bit_i(rx2),
        .sym_en_o(s_sym), .enable_dp_o(s_en), .phase_out_o(s_phase),
        .busy_o(s_busy), .done_o(s_done), .locked_o(s_locked),
        .best_phase_o(s_bphase), .best_err_o(s_berr)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Stimulus/model state
    bit sweeping;
    int sj;
    int nerr[4];
    int eoff[4];
    bit inv_all;
    bit dq[$];

    task automatic reset_model();
        sweeping = 1'b0;
        sj = 0;
        dq.delete();
        for (int i = 0; i < int'(LAT_T); i++) dq.push_back(1'b0);
    endtask

    // One clock: set inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic clk_step(input bit do_start);
        bit r, flip, old;
        int ph, off;
        @(negedge clk);
        start_i = do_start;
        if (sym_en_o === 1'b1) begin
            r = 1'($urandom_range(0, 1));
            flip = 1'b0;
            if (sweeping) begin
                ph  = sj / int'(PH_SYM);
                off = sj % int'(PH_SYM);
                if (ph < 4) begin
                    if (inv_all) flip = 1'b1;
                    else if (off < int'(S_T)) flip = 1'($urandom_range(0, 1));
                    else flip = (off - int'(S_T) >= eoff[ph]) &&
                                (off - int'(S_T) < eoff[ph] + nerr[ph]);
                end
                sj++;
            end
            old = dq.pop_front();
            dq.push_back(r);
            rx_bit_i  = old ^ flip;
            ref_bit_i = r;
        end
        if (do_start && !sweeping) begin
            sweeping = 1'b1;
            sj = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start_i = 1'b0; ref_bit_i = 1'b0; rx_bit_i = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({sym_en_o, enable_dp_o, phase_out_o, busy_o, done_o,
                                  locked_o, best_phase_o, best_err_o}), 0);
        rst = 1'b1;
        reset_model();
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check("enable_dp", 32'(enable_dp_o), 1);
            check("sym_en_k", 32'(sym_en_o), 32'((k % int'(OS_T)) == 0));
        end
        check("idle_state", 32'({phase_out_o, busy_o, done_o}), 0);
    endtask

    task automatic run_sweep(input int pulse_at, input int abort_at);
        int cyc;
        bit seen;
        int e[4];
        int bp, be;
        for (int p = 0; p < 4; p++) begin
            e[p] = inv_all ? int'(W_T) : nerr[p];
            if (e[p] > (1 << EW_T) - 1) e[p] = (1 << EW_T) - 1;
        end
        be = e[0];
        for (int p = 1; p < 4; p++) if (e[p] < be) be = e[p];
        bp = 0;
        while (e[bp] != be) bp++;

        clk_step(1'b1);
        check("start_busy", 32'(busy_o), 1);
        check("start_phase", 32'(phase_out_o), 0);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < int'(LEN_HI) + 20) begin
            clk_step(cyc == pulse_at);
            cyc++;
            if (abort_at > 0 && cyc == abort_at) begin
                check("abort_phase", 32'(phase_out_o), 2);
                #2 rst = 1'b0;
                #1;
                check("abort_outputs", 32'({sym_en_o, enable_dp_o, phase_out_o, busy_o, done_o,
                                            locked_o, best_phase_o, best_err_o}), 0);
                sweeping = 1'b0;
                return;
            end
            if (done_o === 1'b1) begin
                seen = 1'b1;
                sweeping = 1'b0;
                check("sweep_len_in_range", 32'(cyc >= int'(LEN_LO) && cyc <= int'(LEN_HI)), 1);
                check("done_busy", 32'(busy_o), 0);
                check("done_phase_out", 32'(phase_out_o), 32'(bp));
                check("best_phase", 32'(best_phase_o), 32'(bp));
                check("best_err", 32'(best_err_o), 32'(be));
                check("locked", 32'(locked_o), 32'(be <= int'(EM_T)));
            end else if (busy_o !== 1'b1) begin
                check("busy_during_sweep", 32'(busy_o), 1);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        clk_step(1'b0);
        check("done_single_pulse", 32'(done_o), 0);
        repeat (5) clk_step(1'b0);
        check("hold_phase_out", 32'(phase_out_o), 32'(bp));
        check("hold_busy", 32'(busy_o), 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        ref2 = 1'b0;
        rx2 = 1'b1;
        inv_all = 1'b0;
        reset_model();
        do_reset();

        // Loopback: clean only at phase 2.
        nerr[0] = $urandom_range(1, 60); nerr[1] = $urandom_range(1, 60);
        nerr[2] = 0;                     nerr[3] = $urandom_range(1, 60);
        for (int p = 0; p < 4; p++) eoff[p] = $urandom_range(0, int'(W_T) - nerr[p]);
        run_sweep(-1, 0);

        // Tie at phases 1 and 3; stray start pulse during phase 0 measurement.
        nerr[0] = 12; nerr[1] = 5; nerr[2] = 9; nerr[3] = 5;
        for (int p = 0; p < 4; p++) eoff[p] = $urandom_range(0, int'(W_T) - nerr[p]);
        run_sweep(200, 0);

        // Reset during phase 2 settle.
        for (int p = 0; p < 4; p++) begin
            nerr[p] = $urandom_range(0, 40);
            eoff[p] = $urandom_range(0, int'(W_T) - nerr[p]);
        end
        run_sweep(-1, int'(2 * PH_SYM * OS_T + 10 * OS_T));
        do_reset();

        // Restart after reset with rx inverted on every symbol.
        inv_all = 1'b1;
        run_sweep(-1, 0);
        inv_all = 1'b0;

        // Saturation on the narrow instance: an error on every strobe.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cyc = 0;
        while (s_done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("sat_done_seen", 32'(s_done), 1);
        check("sat_best_err", 32'(s_berr), 15);
        check("sat_best_phase", 32'(s_bphase), 0);
        check("sat_locked", 32'(s_locked), 0);
        check("sat_phase_out", 32'(s_phase), 0);
        check("sat_busy", 32'(s_busy), 0);
        check("sat_sym_en_dp", 32'(s_en), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
